reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Ordered reset release for the SoC's reset domains. Consumes the synchronous, active-high reset produced by the reset conditioner. Releases one reset output per domain in fixed order 0..STAGES-1, with a programmable spacing delay and a per-stage ready acknowledgement. An optional watchdog detects a stage that never acknowledges.

## Interface
Parameters:
- STAGES, 4: number of sequenced reset domains (≥1).
- STAGE_DELAY, 16: cycles counted before each release (≥1).
- DELAY_WIDTH, 8: counter width; must hold STAGE_DELAY-1 and TIMEOUT.
- TIMEOUT, 255: max WAIT_ACK cycles per stage (used only with the timeout macro).

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset, driven by the conditioned reset.
- soft_reset_req  input  1  level/pulse; restarts the whole sequence.
- stage_ack  input  STAGES  per-domain ready, level, synchronous to clk.
- stage_rst  output  STAGES  per-domain reset, active-high.
- all_released  output  1  high once every stage is released and acknowledged.
- fault  output  1  ack-timeout flag.
- fault_stage  output  $clog2(STAGES) (min 1)  index of the timed-out stage.

## Operation
- Reset values while rst=1:
  - stage_rst = all ones; all_released=0; fault=0; fault_stage=0.
  - state=HOLD; idx=0; counter=0.
- HOLD: first edge with rst=0 → DELAY, counter←STAGE_DELAY-1.
- DELAY: counter≠0 → decrement. counter==0 → clear stage_rst[idx], go to WAIT_ACK, timeout counter←0.
- WAIT_ACK: stage_ack[idx] is sampled starting the cycle after release.
  - If high and idx==STAGES-1 → DONE, all_released←1.
  - If high otherwise → idx++, counter←STAGE_DELAY-1, go to DELAY.
- DONE: holds. Later stage_ack changes are ignored.
- FAULT (macro only): all stage_rst←1, fault←1, fault_stage←idx, all_released=0. Holds until rst or soft_reset_req.
- Acks of stages already released are ignored. Acks of stages not yet released are ignored until that stage's WAIT_ACK.
- soft_reset_req=1 in any state other than HOLD:
  - next edge: stage_rst all ones, all_released←0, fault←0, fault_stage←0, idx←0, state HOLD.
  - Sequence reruns once soft_reset_req=0 (HOLD waits while it is high).
- Priority: rst > soft_reset_req > FSM progress.
- stage_rst bits only deassert in ascending index order. They reassert only together, on rst, soft_reset_req or fault.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- stage_rst[0] falls STAGE_DELAY+1 edges after the first edge with rst=0.
- With ack already high, consecutive releases are STAGE_DELAY+1 cycles apart.
- Acked stage i → release of stage i+1: STAGE_DELAY edges after the edge sampling the ack.
- all_released rises on the edge after the final stage_ack is sampled high.
- With STAGES=4 and STAGE_DELAY=16 (acks tied high): release edges are 17, 34, 51, 68; all_released at edge 69.
- Timeout: fault asserts on the edge where the WAIT_ACK counter reaches TIMEOUT with no ack. That is TIMEOUT+1 cycles after release.
- rst asserted mid-sequence: outputs return to reset values on the next edge; counters clear.

## Configuration
- RESET_SEQUENCER_TIMEOUT_EN defined:
  - WAIT_ACK counter is active.
  - FAULT state is reachable.
  - fault and fault_stage are live.
- Not defined:
  - WAIT_ACK waits indefinitely.
  - No timeout counter or FAULT state is built.
  - fault tied 0; fault_stage tied 0.
  - TIMEOUT is ignored.

## Structure
- Shared package reset_sequencer_pkg holds:
  - state enum: HOLD, DELAY, WAIT_ACK, DONE, FAULT.
  - localparams for state encoding width.
  - fault_stage width function.
- One sub-module, sequencer_delay_counter: loadable down-counter with a zero flag, DELAY_WIDTH bits.
  - Instantiated for the spacing delay.
  - Instantiated again, as an up-count, for the timeout under the macro.
- The FSM and output registers stay in reset_sequencer.

## Test plan
- Power-up, STAGES=4, STAGE_DELAY=16, acks tied 1: deassert rst → stage_rst 1111→1110@17, 1100@34, 1000@51, 0000@68; all_released@69.
- Stage 2 ack held 0 for 40 cycles after its release, then 1 → stage_rst stays 1000 during the hold; stage 3 releases 16 edges after the ack sample.
- soft_reset_req pulsed 1 cycle in DONE → stage_rst=1111 and all_released=0 next edge; full sequence repeats with identical timing.
- rst asserted while in DELAY of stage 1 → next edge: stage_rst=1111, all state cleared; restart timing matches power-up.
- Macro on, TIMEOUT=255, stage 1 ack never rises → fault=1, fault_stage=1, stage_rst=1111 at release+256; soft_reset_req clears fault.
- Macro off, stage 0 ack never rises → no fault; stage_rst=1110 indefinitely; a late ack resumes the sequence normally.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared state encoding and sizing helpers for the reset sequencer
package reset_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    HOLD     = 3'd0,
    DELAY    = 3'd1,
    WAIT_ACK = 3'd2,
    DONE     = 3'd3,
    FAULT    = 3'd4
  } seq_state_e;

  // Index width for a stage number; never narrower than one bit.
  function automatic int fault_stage_width(input int stages);
    return (stages > 1) ? $clog2(stages) : 1;
  endfunction

endpackage

// File: rtl/sequencer_delay_counter.sv
// rtl/sequencer_delay_counter.sv - loadable counter; expired flags zero (down) or LIMIT (up)
module sequencer_delay_counter #(
  parameter int WIDTH    = 8,
  parameter bit COUNT_UP = 1'b0,
  parameter int LIMIT    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (en) begin
      if (COUNT_UP) begin
        count_d = count_q + WIDTH'(1);
      end else if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = COUNT_UP ? (count_q == WIDTH'(LIMIT)) : (count_q == '0);

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered per-domain reset release with ack handshake
// Optional ack watchdog enabled by defining RESET_SEQUENCER_TIMEOUT_EN.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int STAGES      = 4,
  parameter int STAGE_DELAY = 16,
  parameter int DELAY_WIDTH = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    soft_reset_req,
  input  logic [STAGES-1:0]                       stage_ack,
  output logic [STAGES-1:0]                       stage_rst,
  output logic                                    all_released,
  output logic                                    fault,
  output logic [fault_stage_width(STAGES)-1:0]    fault_stage
);

  localparam int IDX_W = fault_stage_width(STAGES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STAGES - 1);
  localparam logic [DELAY_WIDTH-1:0] DELAY_RELOAD = DELAY_WIDTH'(STAGE_DELAY - 1);

  if (STAGES < 1 || STAGE_DELAY < 1 ||
      (STAGE_DELAY - 1) >= (1 << DELAY_WIDTH) ||
      TIMEOUT >= (1 << DELAY_WIDTH)) begin : g_param_check
    $error("reset_sequencer: parameters out of range for DELAY_WIDTH");
  end

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [STAGES-1:0] stage_rst_q, stage_rst_d;
  logic              all_released_q, all_released_d;

  logic dly_load;
  logic dly_en;
  logic dly_expired;

  sequencer_delay_counter #(
    .WIDTH    (DELAY_WIDTH),
    .COUNT_UP (1'b0),
    .LIMIT    (0)
  ) u_spacing (
    .clk        (clk),
    .rst        (rst),
    .load       (dly_load),
    .load_value (DELAY_RELOAD),
    .en         (dly_en),
    .expired    (dly_expired)
  );

`ifdef RESET_SEQUENCER_TIMEOUT_EN
  logic             fault_q, fault_d;
  logic [IDX_W-1:0] fault_stage_q, fault_stage_d;
  logic             tmo_load;
  logic             tmo_en;
  logic             tmo_expired;

  // Counts WAIT_ACK cycles up from zero; expires once it has reached TIMEOUT.
  sequencer_delay_counter #(
    .WIDTH    (DELAY_WIDTH),
    .COUNT_UP (1'b1),
    .LIMIT    (TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .load       (tmo_load),
    .load_value ('0),
    .en         (tmo_en),
    .expired    (tmo_expired)
  );
`endif

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    stage_rst_d    = stage_rst_q;
    all_released_d = all_released_q;
    dly_load       = 1'b0;
    dly_en         = 1'b0;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
    fault_d        = fault_q;
    fault_stage_d  = fault_stage_q;
    tmo_load       = 1'b0;
    tmo_en         = 1'b0;
`endif

    if (soft_reset_req && state_q != HOLD) begin
      state_d        = HOLD;
      idx_d          = '0;
      stage_rst_d    = '1;
      all_released_d = 1'b0;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
      fault_d        = 1'b0;
      fault_stage_d  = '0;
`endif
    end else begin
      case (state_q)
        HOLD: begin
          if (!soft_reset_req) begin
            state_d  = DELAY;
            dly_load = 1'b1;
          end
        end
        DELAY: begin
          if (dly_expired) begin
            stage_rst_d[idx_q] = 1'b0;
            state_d            = WAIT_ACK;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
            tmo_load           = 1'b1;
`endif
          end else begin
            dly_en = 1'b1;
          end
        end
        WAIT_ACK: begin
          if (stage_ack[idx_q]) begin
            if (idx_q == LAST_IDX) begin
              state_d        = DONE;
              all_released_d = 1'b1;
            end else begin
              idx_d    = idx_q + IDX_W'(1);
              dly_load = 1'b1;
              state_d  = DELAY;
            end
          end
`ifdef RESET_SEQUENCER_TIMEOUT_EN
          else if (tmo_expired) begin
            state_d        = FAULT;
            stage_rst_d    = '1;
            all_released_d = 1'b0;
            fault_d        = 1'b1;
            fault_stage_d  = idx_q;
          end else begin
            tmo_en = 1'b1;
          end
`endif
        end
        DONE:    ;
        FAULT:   ;
        default: state_d = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= HOLD;
      idx_q          <= '0;
      stage_rst_q    <= '1;
      all_released_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      stage_rst_q    <= stage_rst_d;
      all_released_q <= all_released_d;
    end
  end

  assign stage_rst    = stage_rst_q;
  assign all_released = all_released_q;

`ifdef RESET_SEQUENCER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q       <= 1'b0;
      fault_stage_q <= '0;
    end else begin
      fault_q       <= fault_d;
      fault_stage_q <= fault_stage_d;
    end
  end

  assign fault       = fault_q;
  assign fault_stage = fault_stage_q;
`else
  assign fault       = 1'b0;
  assign fault_stage = '0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed bench for reset_sequencer (4 stages, delay 16)
module tb_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       soft_reset_req;
  logic [3:0] stage_ack;
  logic [3:0] stage_rst;
  logic       all_released;
  logic       fault;
  logic [1:0] fault_stage;

  int n_vec;
  int n_err;
  int cyc;

  reset_sequencer #(
    .STAGES      (4),
    .STAGE_DELAY (16),
    .DELAY_WIDTH (8),
    .TIMEOUT     (255)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .soft_reset_req (soft_reset_req),
    .stage_ack      (stage_ack),
    .stage_rst      (stage_rst),
    .all_released   (all_released),
    .fault          (fault),
    .fault_stage    (fault_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic go_to(input int target);
    if (target > cyc) tick(target - cyc);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_sequence(input string tag);
    go_to(16); chk({tag, " rst@16"}, 32'(stage_rst), 32'hF);
    go_to(17); chk({tag, " rst@17"}, 32'(stage_rst), 32'hE);
    go_to(33); chk({tag, " rst@33"}, 32'(stage_rst), 32'hE);
    go_to(34); chk({tag, " rst@34"}, 32'(stage_rst), 32'hC);
    go_to(51); chk({tag, " rst@51"}, 32'(stage_rst), 32'h8);
    go_to(67); chk({tag, " rst@67"}, 32'(stage_rst), 32'h8);
    go_to(68); chk({tag, " rst@68"}, 32'(stage_rst), 32'h0);
               chk({tag, " allrel@68"}, 32'(all_released), 32'h0);
    go_to(69); chk({tag, " allrel@69"}, 32'(all_released), 32'h1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    rst = 1'b1;
    soft_reset_req = 1'b0;
    stage_ack = 4'b1111;

    tick(3);
    chk("reset stage_rst", 32'(stage_rst), 32'hF);
    chk("reset all_released", 32'(all_released), 32'h0);
    chk("reset fault", 32'(fault), 32'h0);
    chk("reset fault_stage", 32'(fault_stage), 32'h0);

    rst = 1'b0;
    cyc = 0;
    check_sequence("pwr");

    stage_ack = 4'b0000;
    go_to(80);
    chk("done ignores acks rst", 32'(stage_rst), 32'h0);
    chk("done ignores acks allrel", 32'(all_released), 32'h1);
    stage_ack = 4'b1111;

    soft_reset_req = 1'b1;
    tick(1);
    chk("soft stage_rst", 32'(stage_rst), 32'hF);
    chk("soft all_released", 32'(all_released), 32'h0);
    soft_reset_req = 1'b0;
    cyc = 0;
    check_sequence("soft");

    soft_reset_req = 1'b1;
    stage_ack[2] = 1'b0;
    tick(1);
    soft_reset_req = 1'b0;
    cyc = 0;
    go_to(51);  chk("stall rst@51", 32'(stage_rst), 32'h8);
    go_to(90);  chk("stall rst@90", 32'(stage_rst), 32'h8);
                chk("stall allrel@90", 32'(all_released), 32'h0);
    go_to(91);  stage_ack[2] = 1'b1;
    go_to(107); chk("stall rst@107", 32'(stage_rst), 32'h8);
    go_to(108); chk("stall rst@108", 32'(stage_rst), 32'h0);
    go_to(109); chk("stall allrel@109", 32'(all_released), 32'h1);

    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    cyc = 0;
    go_to(20);  chk("midrst pre rst", 32'(stage_rst), 32'hE);
    rst = 1'b1;
    tick(1);
    chk("midrst stage_rst", 32'(stage_rst), 32'hF);
    chk("midrst all_released", 32'(all_released), 32'h0);
    rst = 1'b0;
    cyc = 0;
    go_to(16);  chk("midrst rst@16", 32'(stage_rst), 32'hF);
    go_to(17);  chk("midrst rst@17", 32'(stage_rst), 32'hE);
    go_to(34);  chk("midrst rst@34", 32'(stage_rst), 32'hC);

`ifdef RESET_SEQUENCER_TIMEOUT_EN
    stage_ack = 4'b1101;
    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    cyc = 0;
    go_to(289); chk("tmo rst@289", 32'(stage_rst), 32'hC);
                chk("tmo fault@289", 32'(fault), 32'h0);
    go_to(290); chk("tmo fault@290", 32'(fault), 32'h1);
                chk("tmo fault_stage@290", 32'(fault_stage), 32'h1);
                chk("tmo rst@290", 32'(stage_rst), 32'hF);
                chk("tmo allrel@290", 32'(all_released), 32'h0);
    go_to(300); chk("tmo fault holds", 32'(fault), 32'h1);
    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    chk("tmo soft fault", 32'(fault), 32'h0);
    chk("tmo soft fault_stage", 32'(fault_stage), 32'h0);
    chk("tmo soft rst", 32'(stage_rst), 32'hF);
`else
    stage_ack = 4'b1110;
    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    cyc = 0;
    go_to(17);  chk("noack rst@17", 32'(stage_rst), 32'hE);
    go_to(320); chk("noack rst@320", 32'(stage_rst), 32'hE);
                chk("noack fault", 32'(fault), 32'h0);
                chk("noack fault_stage", 32'(fault_stage), 32'h0);
                chk("noack allrel", 32'(all_released), 32'h0);
    stage_ack = 4'b1111;
    go_to(336); chk("lateack rst@336", 32'(stage_rst), 32'hE);
    go_to(337); chk("lateack rst@337", 32'(stage_rst), 32'hC);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
